// File: rtl/imu_tilt.sv
// Tilt classifier for the IMU reader's 96-bit sample word: detects fresh samples,
// smooths accel x/y with an EMA and emits a debounced, hysteretic direction code.
module imu_tilt #(
    parameter int SHIFT  = 2,
    parameter int THRESH = 4000,
    parameter int HYST   = 1000,
    parameter int STABLE = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [95:0]        imu_data,
    output logic signed [15:0] avg_x,
    output logic signed [15:0] avg_y,
    output logic [2:0]         dir,
    output logic               sample_tick
);

    localparam logic [2:0] D_CENTER = 3'd0;
    localparam logic [2:0] D_LEFT   = 3'd1;
    localparam logic [2:0] D_RIGHT  = 3'd2;
    localparam logic [2:0] D_UP     = 3'd3;
    localparam logic [2:0] D_DOWN   = 3'd4;

    localparam logic signed [16:0] L_TH     = 17'(THRESH);
    localparam logic signed [16:0] L_HT     = 17'(THRESH - HYST);
    localparam logic [3:0]         L_STABLE = 4'(STABLE);

    typedef enum logic {S_IDLE, S_EVAL} state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [95:0]        r_prev;
    logic               r_primed;
    logic signed [15:0] r_avg_x;
    logic signed [15:0] r_avg_y;
    logic               r_tick;
    logic [2:0]         r_dir;
    logic [2:0]         r_pend;
    logic [3:0]         r_cnt;

    logic               w_new;
    logic signed [15:0] w_sx;
    logic signed [15:0] w_sy;
    logic signed [16:0] w_ax17;
    logic signed [16:0] w_ay17;
    logic [16:0]        w_mag_x;
    logic [16:0]        w_mag_y;
    logic               w_x_dom;
    logic signed [16:0] w_dom;
    logic               w_held;
    logic [2:0]         w_cand;
    logic [2:0]         w_pend_nx;
    logic [3:0]         w_cnt_nx;
    logic [2:0]         w_dir_nx;

    // Difference is taken at 17 bits; the step never exceeds it, so the 16-bit sum is exact.
    function automatic logic signed [15:0] ema(input logic signed [15:0] avg,
                                               input logic signed [15:0] s);
        logic signed [16:0] diff;
        diff = 17'(s) - 17'(avg);
        return avg + 16'(diff >>> SHIFT);
    endfunction

    function automatic logic [16:0] mag(input logic signed [15:0] v);
        logic signed [16:0] e;
        e = 17'(v);
        return (e < 0) ? 17'(-e) : 17'(e);
    endfunction

    assign w_new = (imu_data != r_prev);
    assign w_sx  = imu_data[47:32];
    assign w_sy  = imu_data[31:16];

    // Sample capture and EMA; a back-to-back sample updates here while EVAL reads the old averages.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev   <= '0;
            r_primed <= 1'b0;
            r_avg_x  <= '0;
            r_avg_y  <= '0;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= w_new;
            if (w_new) begin
                r_prev   <= imu_data;
                r_primed <= 1'b1;
                r_avg_x  <= r_primed ? ema(r_avg_x, w_sx) : w_sx;
                r_avg_y  <= r_primed ? ema(r_avg_y, w_sy) : w_sy;
            end
        end
    end

    assign w_ax17  = 17'(r_avg_x);
    assign w_ay17  = 17'(r_avg_y);
    assign w_mag_x = mag(r_avg_x);
    assign w_mag_y = mag(r_avg_y);

    always_comb begin
        case (r_dir)
            D_RIGHT: w_held = (w_ax17 >  L_HT);
            D_LEFT:  w_held = (w_ax17 < -L_HT);
            D_UP:    w_held = (w_ay17 >  L_HT);
            D_DOWN:  w_held = (w_ay17 < -L_HT);
            default: w_held = 1'b0;
        endcase
    end

    // Ties in magnitude go to the x axis.
    always_comb begin
        w_x_dom = (w_mag_x >= w_mag_y);
        w_dom   = w_x_dom ? w_ax17 : w_ay17;
        if (w_held)
            w_cand = r_dir;
        else if (w_dom > L_TH)
            w_cand = w_x_dom ? D_RIGHT : D_UP;
        else if (w_dom < -L_TH)
            w_cand = w_x_dom ? D_LEFT : D_DOWN;
        else
            w_cand = D_CENTER;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  w_state_nx = w_new ? S_EVAL : S_IDLE;
            S_EVAL:  w_state_nx = w_new ? S_EVAL : S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_pend_nx = r_pend;
        w_cnt_nx  = r_cnt;
        w_dir_nx  = r_dir;
        if (r_state == S_EVAL) begin
            if (w_cand == r_pend) begin
                w_cnt_nx = (r_cnt >= L_STABLE) ? L_STABLE : r_cnt + 4'd1;
            end else begin
                w_pend_nx = w_cand;
                w_cnt_nx  = 4'd1;
            end
            if ((w_cnt_nx >= L_STABLE) && (w_pend_nx != r_dir))
                w_dir_nx = w_pend_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= D_CENTER;
            r_cnt  <= '0;
            r_dir  <= D_CENTER;
        end else begin
            r_pend <= w_pend_nx;
            r_cnt  <= w_cnt_nx;
            r_dir  <= w_dir_nx;
        end
    end

    assign avg_x       = r_avg_x;
    assign avg_y       = r_avg_y;
    assign dir         = r_dir;
    assign sample_tick = r_tick;

endmodule

// File: tb/tb_imu_tilt.sv
// Scoreboard bench for imu_tilt: stimulus pushes reference-model results into queues,
// a negedge monitor pops them whenever the DUT ticks and checks averages and direction.
module tb_imu_tilt;
    localparam int SHIFT  = 2;
    localparam int THRESH = 4000;
    localparam int HYST   = 1000;
    localparam int STABLE = 3;

    logic               clk      = 1'b0;
    logic               reset    = 1'b1;
    logic [95:0]        imu_data = '0;
    logic signed [15:0] avg_x;
    logic signed [15:0] avg_y;
    logic [2:0]         dir;
    logic               sample_tick;

    imu_tilt #(.SHIFT(SHIFT), .THRESH(THRESH), .HYST(HYST), .STABLE(STABLE)) dut (
        .clk(clk), .reset(reset), .imu_data(imu_data),
        .avg_x(avg_x), .avg_y(avg_y), .dir(dir), .sample_tick(sample_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int n_ticks  = 0;
    int qx[$];
    int qy[$];
    int qd[$];

    // reference model state
    int          m_ax, m_ay, m_dir, m_pend, m_cnt;
    bit          m_primed;
    logic [95:0] m_prev;

    // monitor state
    int   e_ax = 0, e_ay = 0, e_dir = 0;
    bit   pending = 1'b0;
    logic rst_q = 1'b1;
    int   zc = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_ax = 0; m_ay = 0; m_dir = 0; m_pend = 0; m_cnt = 0;
        m_primed = 1'b0; m_prev = '0;
        qx.delete(); qy.delete(); qd.delete();
    endtask

    task automatic model_apply(input logic [95:0] w);
        int x, y, cand, ht;
        logic [15:0] fx, fy;
        if (w == m_prev) return;
        m_prev = w;
        fx = w[47:32];
        fy = w[31:16];
        x = int'($signed(fx));
        y = int'($signed(fy));
        if (!m_primed) begin
            m_ax = x; m_ay = y; m_primed = 1'b1;
        end else begin
            m_ax = m_ax + ((x - m_ax) >>> SHIFT);
            m_ay = m_ay + ((y - m_ay) >>> SHIFT);
        end
        qx.push_back(m_ax);
        qy.push_back(m_ay);
        ht = THRESH - HYST;
        if ((m_dir == 2 && m_ax > ht) || (m_dir == 1 && m_ax < -ht) ||
            (m_dir == 3 && m_ay > ht) || (m_dir == 4 && m_ay < -ht))
            cand = m_dir;
        else if (iabs(m_ax) >= iabs(m_ay))
            cand = (m_ax > THRESH) ? 2 : (m_ax < -THRESH) ? 1 : 0;
        else
            cand = (m_ay > THRESH) ? 3 : (m_ay < -THRESH) ? 4 : 0;
        if (cand == m_pend) begin
            if (m_cnt < STABLE) m_cnt++;
        end else begin
            m_pend = cand;
            m_cnt  = 1;
        end
        if (m_cnt >= STABLE && m_pend != m_dir) m_dir = m_pend;
        qd.push_back(m_dir);
    endtask

    always @(posedge clk) rst_q <= reset;

    always @(negedge clk) begin
        if (rst_q) begin
            e_ax = 0; e_ay = 0; e_dir = 0; pending = 1'b0;
            check("tick_in_reset", sample_tick, 0);
        end else begin
            if (pending) begin
                if (qd.size() == 0) check("dir_queue_len", qd.size(), 1);
                else e_dir = qd.pop_front();
            end
            pending = sample_tick;
            if (sample_tick) begin
                n_ticks++;
                if (qx.size() == 0) check("tick_queue_len", qx.size(), 1);
                else begin
                    e_ax = qx.pop_front();
                    e_ay = qy.pop_front();
                end
            end
        end
        check("avg_x", avg_x, e_ax);
        check("avg_y", avg_y, e_ay);
        check("dir", dir, e_dir);
    end

    function automatic logic [95:0] mk(input int x, input int y);
        zc++;
        return {48'h0, 16'(x), 16'(y), 16'(zc)};
    endfunction

    task automatic drive(input logic [95:0] w);
        @(posedge clk); #1;
        imu_data = w;
        model_apply(w);
    endtask

    // waits past the edge that samples the last driven word
    task automatic settle();
        @(posedge clk); @(negedge clk); #1;
    endtask

    task automatic settle2();
        settle();
        @(negedge clk); #1;
    endtask

    task automatic do_reset(input int n, input logic [95:0] hold);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        imu_data = hold;
        model_reset();
        repeat (n) @(posedge clk);
        @(negedge clk); #1;
        check("rst_avg_x", avg_x, 0);
        check("rst_avg_y", avg_y, 0);
        check("rst_dir", dir, 0);
        check("rst_tick", sample_tick, 0);
        reset = 1'b0;
        model_apply(hold);
    endtask

    function automatic int rv();
        logic [15:0] r16;
        int off;
        off = int'($urandom_range(0, 1600)) - 800;
        case ($urandom_range(0, 5))
            0: begin r16 = 16'($urandom); return int'($signed(r16)); end
            1: return $urandom_range(0, 1) ? THRESH + off : -(THRESH + off);
            2: return $urandom_range(0, 1) ? (THRESH - HYST) + off : -((THRESH - HYST) + off);
            3: return -32768;
            4: return 32767;
            default: return off / 4;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [95:0] w;
        int t0, tx, ty, x, y;

        // reset defaults, then quiet idle
        do_reset(3, '0);
        repeat (20) @(posedge clk);
        @(negedge clk); #1;
        check("idle_ticks", n_ticks, 0);

        // priming
        drive(mk(8000, -200));
        settle();
        check("prime_x", avg_x, 8000);
        check("prime_y", avg_y, -200);
        check("prime_ticks", n_ticks, 1);

        // EMA arithmetic
        do_reset(1, '0);
        drive(mk(0, 0));
        drive(mk(4000, 0)); settle(); check("ema1", avg_x, 1000);
        drive(mk(4000, 0)); settle(); check("ema2", avg_x, 1750);
        drive(mk(4000, 0)); settle(); check("ema3", avg_x, 2312);
        do_reset(1, '0);
        drive(mk(0, 0));
        drive(mk(-1, 0)); settle(); check("ema_neg", avg_x, -1);

        // repeated identical words give one tick only
        do_reset(1, '0);
        t0 = n_ticks;
        w = mk(8000, 0);
        repeat (5) drive(w);
        settle2();
        check("repeat_ticks", n_ticks - t0, 1);
        check("repeat_dir", dir, 0);

        // debounce entry: RIGHT exactly two edges after the third word
        do_reset(1, '0);
        drive(mk(8000, 0));
        drive(mk(8000, 0));
        drive(mk(8000, 0));
        @(negedge clk); #1;
        check("deb_pre", dir, 0);
        @(negedge clk); #1;
        check("deb_edge1", dir, 0);
        @(negedge clk); #1;
        check("deb_edge2", dir, 2);

        // hysteresis: RIGHT holds near 3500, drops to CENTER below 3000
        repeat (5) drive(mk(2000, 0));
        settle2();
        check("hyst_avg", avg_x, 3423);
        check("hyst_hold", dir, 2);
        repeat (3) drive(mk(0, 0));
        settle2();
        check("hyst_avg_low", avg_x, 1443);
        check("hyst_release", dir, 0);

        // tie goes to x
        do_reset(1, '0);
        repeat (3) drive(mk(-5000, 5000));
        settle2();
        check("tie_dir", dir, 1);

        // back-to-back samples
        t0 = n_ticks;
        repeat (4) drive(mk(int'($urandom_range(0, 20000)) - 10000, int'($urandom_range(0, 20000)) - 10000));
        settle2();
        check("b2b_ticks", n_ticks - t0, 4);

        // reset while UP, then first sample primes
        do_reset(1, '0);
        repeat (3) drive(mk(0, 10000));
        settle2();
        check("up_dir", dir, 3);
        w = mk(1234, -4321);
        do_reset(1, w);
        settle();
        check("post_rst_x", avg_x, 1234);
        check("post_rst_y", avg_y, -4321);

        // randomized traffic around the thresholds
        tx = 0; ty = 0;
        for (int i = 0; i < 600; i++) begin
            int op;
            if (i % 12 == 0) begin tx = rv(); ty = rv(); end
            op = int'($urandom_range(0, 99));
            if (op < 70) begin
                x = tx + int'($urandom_range(0, 600)) - 300;
                y = ty + int'($urandom_range(0, 600)) - 300;
                drive({16'($urandom), 16'($urandom), 16'($urandom), 16'(x), 16'(y), 16'($urandom)});
            end else if (op < 85) begin
                drive(imu_data);
            end else if (op < 87) begin
                do_reset(int'($urandom_range(1, 3)), imu_data);
            end else begin
                @(posedge clk);
            end
        end

        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        check("avg_queue_drained", qx.size(), 0);
        check("dir_queue_drained", qd.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
